alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue controller for the shared 256-bit vector ALU (16 lanes × 16-bit half-precision). Accepts one instruction at a time through a start/busy/done handshake and drives the ALU's op_1/op_2/opcode inputs. Single-pass opcodes complete in one ALU cycle. VDOT runs a lane-wise multiply, then a 15-step serial reduction through the ALU's VADD path, so the pipeline sees a scalar dot product. Sits between decode/issue and the ALU instance in the CVP14 core.

## Interface
- No parameters. Widths are fixed: 256-bit vector, 16-bit lane, 4-bit opcode.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  issue strobe; sampled only when busy=0
- opcode  in  4  instruction opcode; same encoding as the ALU
- op_a  in  256  first operand
- op_b  in  256  second operand
- busy  out  1  instruction in flight; start ignored while high
- done  out  1  one-cycle pulse; result valid from this cycle on
- result  out  256  final result; held until the next done
- alu_op1  out  256  to ALU op_1
- alu_op2  out  256  to ALU op_2
- alu_opcode  out  4  to ALU opcode
- alu_result  in  256  from ALU result (combinational)

## Operation
- States: IDLE, EXEC, MUL, ACC.
- IDLE
  - alu_opcode=NOP (4'b1111); alu_op1=alu_op2=0.
  - On start, capture opcode, op_a and op_b.
  - Go to MUL if opcode==VDOT (4'b0001); otherwise go to EXEC.
- EXEC
  - Drive the captured operands and opcode to the ALU.
  - At the edge: result<=alu_result, done<=1, go to IDLE.
  - Unknown opcodes and NOP take this path and produce whatever the ALU returns (0 for NOP).
- MUL
  - Drive the captured operands with alu_opcode=VDOT.
  - At the edge: prod<=alu_result, acc<=alu_result[15:0], k<=1, go to ACC.
- ACC
  - alu_opcode=VADD (4'b0000); alu_op1={240'd0,acc}; alu_op2={240'd0,prod[16k+15:16k]}.
  - At the edge: acc<=alu_result[15:0].
  - If k==15: result<={240'd0, new acc}, done<=1, go to IDLE. Otherwise k<=k+1.
- Reduction order is fixed, left-associative (((p0+p1)+p2)+…+p15), so rounding is deterministic. Lane k is bits [16k+15:16k].
- k is 4 bits and never wraps. The exit is on k==15, before any increment.
- busy=1 in EXEC, MUL and ACC; busy=0 in IDLE.
- done is registered and coincides with the first IDLE cycle. A start in the done cycle is accepted, giving back-to-back issue.
- Operand changes on op_a/op_b/opcode after capture have no effect on the in-flight instruction.
- Reset, including mid-operation: abort immediately. State=IDLE, busy=0, done=0, result=0, acc=0, prod=0, k=0; ALU outputs take IDLE values.

## Timing
- start sampled at edge E0.
- Non-VDOT: EXEC occupies cycle 1; done=1 and result valid in cycle 2. Latency is 2 cycles; issue interval is 2 cycles.
- VDOT:
  - MUL occupies cycle 1.
  - ACC occupies cycles 2–16 (15 steps).
  - done=1 in cycle 17. Latency is 17 cycles; issue interval is 17.
- The ALU is combinational. alu_* outputs are decoded from registered state only, so there is no start→alu_op1 combinational path.
- done is high for exactly one cycle per accepted start.

## Structure
- Shared package/include cvp14_defs:
  - opcode localparams (VADD, VDOT, SMUL, SST, VLD, VST, SLL, SLH, J, NOP)
  - LANE_W=16, LANES=16, VEC_W=256
- The state encoding is local to this module.
- The ALU is instantiated by the parent, not inside this block.
- One natural sub-module: lane_select (256→16 mux indexed by k), reused later by scalar-extract paths.

## Test plan
Half-precision constants: 3C00=1.0, 4000=2.0, 5000=32.0, 4200=3.0.

- **VDOT:** all lanes 3C00 · all lanes 4000 → done at cycle 17; result={240'd0,16'h5000}; busy high cycles 1–16.
- **VADD:** op_a lane0=3C00, op_b lane0=4000, other lanes 0 → done at cycle 2; result lane0=4200, other lanes 0.
- **Back-to-back:** VADD, with start re-asserted for VADD in the done cycle → second done at cycle 4; exactly two done pulses.
- **Start while busy:** start pulsed during VDOT cycle 8 → ignored; a single done at cycle 17; result unchanged by the ignored operands.
- **Reset mid-VDOT:** rst_n low at cycle 9 → busy, done and result go to 0 asynchronously and alu_opcode=NOP. After release, a fresh VADD completes normally.
- **Operand stability / NOP:** op_a changed after start → result reflects the captured values. NOP issued → done at cycle 2 with result=0.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared CVP14 vector-ALU definitions: geometry and opcode encoding.
package alu_sequencer_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 16;
  localparam int VEC_W  = 256;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_VADD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_VDOT = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SMUL = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SST  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_VLD  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_VST  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SLL  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SLH  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_J    = 4'b1000;
  localparam logic [OPC_W-1:0] OP_NOP  = 4'b1111;

endpackage

// File: rtl/alu_sequencer_lane_select.sv
// Picks one 16-bit lane out of a 256-bit vector; lane k is bits [16k+15:16k].
module alu_sequencer_lane_select
  import alu_sequencer_pkg::*;
(
  input  logic [VEC_W-1:0]  vec_i,
  input  logic [3:0]        sel_i,
  output logic [LANE_W-1:0] lane_o
);

  assign lane_o = vec_i[{sel_i, 4'd0} +: LANE_W];

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller for the shared vector ALU: single-pass ops in one ALU cycle,
// VDOT as a lane-wise multiply followed by a 15-step left-associative VADD reduction.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [VEC_W-1:0]  op_a,
  input  logic [VEC_W-1:0]  op_b,
  output logic              busy,
  output logic              done,
  output logic [VEC_W-1:0]  result,
  output logic [VEC_W-1:0]  alu_op1,
  output logic [VEC_W-1:0]  alu_op2,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [VEC_W-1:0]  alu_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_ACC  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [VEC_W-1:0]  opa_q, opa_d;
  logic [VEC_W-1:0]  opb_q, opb_d;
  logic [VEC_W-1:0]  prod_q, prod_d;
  logic [VEC_W-1:0]  result_q, result_d;
  logic [LANE_W-1:0] acc_q, acc_d;
  logic [LANE_W-1:0] lane_s;
  logic [3:0]        k_q, k_d;
  logic              done_q, done_d;

  alu_sequencer_lane_select u_lane_select (
    .vec_i  (prod_q),
    .sel_i  (k_q),
    .lane_o (lane_s)
  );

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

  // State and datapath registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opc_q    <= OP_NOP;
      opa_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      acc_q    <= 16'd0;
      k_q      <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      done_q   <= done_d;
    end
  end

  // Next-state and ALU drive; ALU inputs depend only on registered state.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    prod_d     = prod_q;
    result_d   = result_q;
    acc_d      = acc_q;
    k_d        = k_q;
    done_d     = 1'b0;
    alu_opcode = OP_NOP;
    alu_op1    = '0;
    alu_op2    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opc_d   = opcode;
          opa_d   = op_a;
          opb_d   = op_b;
          state_d = (opcode == OP_VDOT) ? ST_MUL : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        alu_opcode = opc_q;
        alu_op1    = opa_q;
        alu_op2    = opb_q;
        result_d   = alu_result;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_MUL: begin
        alu_opcode = OP_VDOT;
        alu_op1    = opa_q;
        alu_op2    = opb_q;
        prod_d     = alu_result;
        acc_d      = alu_result[LANE_W-1:0];
        k_d        = 4'd1;
        state_d    = ST_ACC;
      end
      ST_ACC: begin
        alu_opcode = OP_VADD;
        alu_op1    = {{(VEC_W-LANE_W){1'b0}}, acc_q};
        alu_op2    = {{(VEC_W-LANE_W){1'b0}}, lane_s};
        acc_d      = alu_result[LANE_W-1:0];
        // Exit is tested before the increment so k never wraps.
        if (k_q == 4'd15) begin
          result_d = {{(VEC_W-LANE_W){1'b0}}, alu_result[LANE_W-1:0]};
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural half-precision ALU
// and a transaction-level latency/result model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   opcode = OP_NOP;
  logic [255:0] op_a = '0;
  logic [255:0] op_b = '0;
  logic         busy, done;
  logic [255:0] result, alu_op1, alu_op2, alu_result;
  logic [3:0]   alu_opcode;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real v;
    v = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) v = v * 2.0;
    else        for (int i = 0; i < -n; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m, v;
    e = int'(h[14:10]);
    m = real'(int'(h[9:0]));
    if (e == 0) v = m * pow2(-24);
    else        v = (1.0 + m / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e, f;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a < pow2(-14)) return {s, 15'd0};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    f = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (f == 1024) begin f = 0; e++; end
    if (e > 15) return {s, 5'h1f, 10'd0};
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  // Behavioural ALU: lane-wise fp16 add/multiply, zero for NOP, XOR otherwise.
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < 16; i++) begin
      case (alu_opcode)
        OP_VADD: alu_result[i*16 +: 16] = r2h(h2r(alu_op1[i*16 +: 16]) + h2r(alu_op2[i*16 +: 16]));
        OP_VDOT: alu_result[i*16 +: 16] = r2h(h2r(alu_op1[i*16 +: 16]) * h2r(alu_op2[i*16 +: 16]));
        OP_NOP:  alu_result[i*16 +: 16] = 16'h0000;
        default: alu_result[i*16 +: 16] = alu_op1[i*16 +: 16] ^ alu_op2[i*16 +: 16];
      endcase
    end
  end

  function automatic logic [255:0] expected_result(input logic [3:0] op,
                                                   input logic [255:0] a, b);
    logic [255:0] r;
    logic [15:0]  p [16];
    logic [15:0]  acc;
    r = '0;
    if (op == OP_VDOT) begin
      for (int i = 0; i < 16; i++) p[i] = r2h(h2r(a[i*16 +: 16]) * h2r(b[i*16 +: 16]));
      acc = p[0];
      for (int i = 1; i < 16; i++) acc = r2h(h2r(acc) + h2r(p[i]));
      r[15:0] = acc;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (op == OP_VADD)     r[i*16 +: 16] = r2h(h2r(a[i*16 +: 16]) + h2r(b[i*16 +: 16]));
        else if (op == OP_NOP) r[i*16 +: 16] = 16'h0000;
        else                   r[i*16 +: 16] = a[i*16 +: 16] ^ b[i*16 +: 16];
      end
    end
    return r;
  endfunction

  // Transaction model: cycles remaining until done, result computed at acceptance.
  logic         m_busy = 1'b0, m_done = 1'b0;
  logic [255:0] m_result = '0, m_pend = '0;
  int           m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_result = m_pend;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_rem  = (opcode == OP_VDOT) ? 16 : 1;
        m_pend = expected_result(opcode, op_a, op_b);
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {255'd0, busy}, {255'd0, m_busy});
      chk("done", {255'd0, done}, {255'd0, m_done});
      chk("result", result, m_result);
      if (!m_busy) begin
        chk("idle_opcode", {252'd0, alu_opcode}, {252'd0, OP_NOP});
        chk("idle_op1", alu_op1, 256'd0);
        chk("idle_op2", alu_op2, 256'd0);
      end
    end
  end

  function automatic logic [255:0] splat(input logic [15:0] h);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = h;
    return v;
  endfunction

  // Drives start for the edge E0; returns in the middle of cycle 1.
  task automatic issue(input logic [3:0] op, input logic [255:0] a, b);
    @(negedge clk);
    start = 1'b1; opcode = op; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts from cycle 1 to the done cycle, bounded.
  task automatic wait_done(input string name, input int exp_cyc);
    int cyc;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 256'(cyc), 256'(exp_cyc));
  endtask

  logic [255:0] ramp;
  logic [255:0] va, vb;
  int dcount;

  initial begin
    for (int i = 0; i < 16; i++) ramp[i*16 +: 16] = r2h(real'(i + 1));

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {255'd0, busy}, 256'd0);
    chk("reset_done", {255'd0, done}, 256'd0);
    chk("reset_result", result, 256'd0);
    chk("reset_alu_opcode", {252'd0, alu_opcode}, {252'd0, OP_NOP});
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // VDOT of 1.0 x 2.0 over 16 lanes = 32.0
    issue(OP_VDOT, splat(16'h3C00), splat(16'h4000));
    wait_done("vdot_latency", 17);
    chk("vdot_result", result, {240'd0, 16'h5000});

    // VDOT with distinct lanes: 1+2+...+16 = 136
    issue(OP_VDOT, splat(16'h3C00), ramp);
    wait_done("vdot_ramp_latency", 17);
    chk("vdot_ramp_result", result, {240'd0, 16'h5840});

    // VADD 1.0 + 2.0 in lane 0
    issue(OP_VADD, {240'd0, 16'h3C00}, {240'd0, 16'h4000});
    wait_done("vadd_latency", 2);
    chk("vadd_result", result, {240'd0, 16'h4200});

    // Back-to-back VADD, second start in the done cycle
    issue(OP_VADD, {240'd0, 16'h3C00}, {240'd0, 16'h3C00});
    wait_done("b2b_first_latency", 2);
    start = 1'b1; opcode = OP_VADD; op_a = {240'd0, 16'h4000}; op_b = {240'd0, 16'h3C00};
    dcount = 0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) dcount++;
      if (c == 1) chk("b2b_second_done", {255'd0, done}, 256'd1);
      @(negedge clk);
    end
    chk("b2b_done_count", 256'(dcount), 256'd1);
    chk("b2b_result", result, {240'd0, 16'h4200});

    // Start pulsed during VDOT cycle 8 is ignored
    issue(OP_VDOT, splat(16'h3C00), splat(16'h4000));
    repeat (7) @(negedge clk);
    start = 1'b1; opcode = OP_VADD; op_a = splat(16'h4200); op_b = splat(16'h4200);
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start_latency", 9);
    chk("busy_start_result", result, {240'd0, 16'h5000});
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("busy_start_extra_done", 256'(dcount), 256'd0);

    // Asynchronous reset mid-VDOT
    issue(OP_VDOT, splat(16'h3C00), splat(16'h4000));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_done", {255'd0, done}, 256'd0);
    chk("rst_result", result, 256'd0);
    chk("rst_alu_opcode", {252'd0, alu_opcode}, {252'd0, OP_NOP});
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_VADD, {240'd0, 16'h4000}, {240'd0, 16'h3C00});
    wait_done("post_rst_latency", 2);
    chk("post_rst_result", result, {240'd0, 16'h4200});

    // Operand change after capture has no effect
    issue(OP_VADD, {240'd0, 16'h3C00}, {240'd0, 16'h4000});
    op_a = splat(16'h5000); op_b = splat(16'h5000); opcode = OP_NOP;
    wait_done("stable_latency", 2);
    chk("stable_result", result, {240'd0, 16'h4200});

    // NOP gives zero
    issue(OP_NOP, splat(16'h4200), splat(16'h4000));
    wait_done("nop_latency", 2);
    chk("nop_result", result, 256'd0);

    // Unknown-to-sequencer opcode passes straight through the ALU
    va = splat(16'h1234); vb = splat(16'h00FF);
    issue(OP_SMUL, va, vb);
    wait_done("smul_latency", 2);
    chk("smul_result", result, splat(16'h12CB));

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
